// File: rtl/bcorrect_queue.sv
// Branch-correction FIFO: queues resolution packets and hands them one at a time to the
// backend with a drive/free handshake. Define BCORRECT_QUEUE_STATS_EN for sent/drop counters.
module bcorrect_queue #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_push,
    input  logic        i_flushOnly,
    input  logic [2:0]  i_errPos_3,
    input  logic [2:0]  i_counter_3,
    input  logic [31:0] i_correctPc_32,
    input  logic        i_flush,
    input  logic        i_free_from_back,
    output logic        o_ready,
    output logic        o_drive_to_back,
    output logic [41:0] o_data_42,
    output logic        o_overflow,
    output logic        o_protoErr,
    output logic        o_timeout
`ifdef BCORRECT_QUEUE_STATS_EN
   ,output logic [15:0] o_sentCount_16,
    output logic [7:0]  o_dropCount_8
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [WD_W-1:0]  WD_ZERO  = WD_W'(0);
    localparam logic [WD_W-1:0]  WD_ONE   = WD_W'(1);
    localparam logic [WD_W-1:0]  WD_LIMIT = WD_W'(TIMEOUT);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [41:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [WD_W-1:0]  wd_r;
    logic [41:0]      data_r;
    logic             drive_r;
    logic             ovf_r;
    logic             perr_r;
    logic             tmo_r;

    logic [41:0]      pkt_s;
    logic             ready_s;
    logic             push_ok_s;
    logic             drop_s;
    logic             pop_s;
    logic             keep_s;
    logic             perr_set_s;
    logic             tmo_set_s;
    logic [PTR_W-1:0] rd_nx_s;
    logic [PTR_W-1:0] wr_base_s;
    logic [PTR_W-1:0] wr_nx_s;
    logic [CNT_W-1:0] cnt_base_s;
    logic [CNT_W-1:0] cnt_nx_s;
    logic [WD_W-1:0]  wd_nx_s;

    // Queue bookkeeping: accept/drop, pop on free, and flush that may spare the in-flight head
    always_comb begin
        pkt_s      = {i_flushOnly, i_errPos_3, i_counter_3, 3'b000, i_correctPc_32};
        ready_s    = (cnt_r != CNT_FULL);
        push_ok_s  = i_push & ready_s;
        drop_s     = i_push & ~ready_s;
        pop_s      = (state_r == ST_WAIT) & i_free_from_back;
        perr_set_s = i_free_from_back & (state_r != ST_WAIT);
        // The head survives a flush only while it is owned by the backend and not being freed
        keep_s     = (state_r != ST_IDLE) & ~pop_s;
        if (pop_s) begin
            rd_nx_s = rd_ptr_r + PTR_ONE;
        end else begin
            rd_nx_s = rd_ptr_r;
        end
        if (i_flush) begin
            wr_base_s  = rd_nx_s + PTR_W'(keep_s);
            cnt_base_s = CNT_W'(keep_s);
        end else begin
            wr_base_s  = wr_ptr_r;
            cnt_base_s = cnt_r - CNT_W'(pop_s);
        end
        if (push_ok_s) begin
            wr_nx_s = wr_base_s + PTR_ONE;
        end else begin
            wr_nx_s = wr_base_s;
        end
        cnt_nx_s = cnt_base_s + CNT_W'(push_ok_s);
    end

    // Handshake next-state: a flush in IDLE cancels the send it would otherwise start
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if ((cnt_r != CNT_ZERO) && !i_flush) begin
                    state_nx_s = ST_SEND;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_SEND: state_nx_s = ST_WAIT;
            ST_WAIT: begin
                if (i_free_from_back) begin
                    state_nx_s = ST_IDLE;
                end else begin
                    state_nx_s = ST_WAIT;
                end
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Watchdog: saturating count of cycles spent waiting for the free
    always_comb begin
        if ((state_r == ST_WAIT) && !i_free_from_back) begin
            if (wd_r != WD_LIMIT) begin
                wd_nx_s = wd_r + WD_ONE;
            end else begin
                wd_nx_s = wd_r;
            end
        end else begin
            wd_nx_s = WD_ZERO;
        end
        tmo_set_s = (wd_nx_s == WD_LIMIT);
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Packet storage; contents need no reset because occupancy governs visibility
    always_ff @(posedge clk) begin
        if (rst && push_ok_s) begin
            mem_r[wr_base_s] <= pkt_s;
        end
    end

    // Pointers, occupancy, registered outputs and sticky error flags
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            cnt_r    <= CNT_ZERO;
            wd_r     <= WD_ZERO;
            data_r   <= 42'd0;
            drive_r  <= 1'b0;
            ovf_r    <= 1'b0;
            perr_r   <= 1'b0;
            tmo_r    <= 1'b0;
        end else begin
            rd_ptr_r <= rd_nx_s;
            wr_ptr_r <= wr_nx_s;
            cnt_r    <= cnt_nx_s;
            wd_r     <= wd_nx_s;
            drive_r  <= (state_nx_s == ST_SEND);
            ovf_r    <= ovf_r | drop_s;
            perr_r   <= perr_r | perr_set_s;
            tmo_r    <= tmo_r | tmo_set_s;
            // Latch the head on entry to SEND so it stays stable until the free
            if ((state_r == ST_IDLE) && (state_nx_s == ST_SEND)) begin
                data_r <= mem_r[rd_ptr_r];
            end
        end
    end

    assign o_ready         = ready_s;
    assign o_drive_to_back = drive_r;
    assign o_data_42       = data_r;
    assign o_overflow      = ovf_r;
    assign o_protoErr      = perr_r;
    assign o_timeout       = tmo_r;

`ifdef BCORRECT_QUEUE_STATS_EN
    logic [15:0] sent_cnt_r;
    logic [7:0]  drop_cnt_r;

    // Statistics: wrapping count of accepted frees, saturating count of dropped pushes
    always_ff @(posedge clk) begin
        if (!rst) begin
            sent_cnt_r <= 16'd0;
            drop_cnt_r <= 8'd0;
        end else begin
            if (pop_s) begin
                sent_cnt_r <= sent_cnt_r + 16'd1;
            end
            if (drop_s && (drop_cnt_r != 8'hFF)) begin
                drop_cnt_r <= drop_cnt_r + 8'd1;
            end
        end
    end

    assign o_sentCount_16 = sent_cnt_r;
    assign o_dropCount_8  = drop_cnt_r;
`endif

endmodule

// File: tb/tb_bcorrect_queue.sv
// Self-checking bench for bcorrect_queue: vector table, directed corner sequences and
// randomized traffic against a queue-based reference model.
module tb_bcorrect_queue;

    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_push;
    logic        i_flushOnly;
    logic [2:0]  i_errPos_3;
    logic [2:0]  i_counter_3;
    logic [31:0] i_correctPc_32;
    logic        i_flush;
    logic        i_free_from_back;
    logic        o_ready;
    logic        o_drive_to_back;
    logic [41:0] o_data_42;
    logic        o_overflow;
    logic        o_protoErr;
    logic        o_timeout;
`ifdef BCORRECT_QUEUE_STATS_EN
    logic [15:0] o_sentCount_16;
    logic [7:0]  o_dropCount_8;
`endif

    always #5 clk = ~clk;

    bcorrect_queue #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk              (clk),
        .rst              (rst),
        .i_push           (i_push),
        .i_flushOnly      (i_flushOnly),
        .i_errPos_3       (i_errPos_3),
        .i_counter_3      (i_counter_3),
        .i_correctPc_32   (i_correctPc_32),
        .i_flush          (i_flush),
        .i_free_from_back (i_free_from_back),
        .o_ready          (o_ready),
        .o_drive_to_back  (o_drive_to_back),
        .o_data_42        (o_data_42),
        .o_overflow       (o_overflow),
        .o_protoErr       (o_protoErr),
        .o_timeout        (o_timeout)
`ifdef BCORRECT_QUEUE_STATS_EN
       ,.o_sentCount_16   (o_sentCount_16),
        .o_dropCount_8    (o_dropCount_8)
`endif
    );

    typedef struct {
        logic        rst, push, fo;
        logic [2:0]  ep, ct;
        logic [31:0] pc;
        logic        flush, free;
        logic        e_drive, e_ready;
        logic [41:0] e_data;
        logic        e_ovf, e_perr, e_tmo;
    } vec_t;

    vec_t tbl[$];

    // Reference model: packet queue plus "being offered" / "owned by backend" flags
    logic [41:0] m_q[$];
    bit          m_drive, m_wait, m_ovf, m_perr, m_tmo;
    int          m_wd, m_sent, m_drop;
    logic [41:0] m_data;

    int n_cmp = 0;
    int n_bad = 0;
    int drives_seen = 0;

    function automatic logic [41:0] pack(input logic fo, input logic [2:0] ep,
                                         input logic [2:0] ct, input logic [31:0] pc);
        return (42'(fo) << 41) | (42'(ep) << 38) | (42'(ct) << 35) | 42'(pc);
    endfunction

    function automatic vec_t mkrow(input logic r, input logic push, input logic fo,
                                   input logic [2:0] ep, input logic [2:0] ct, input logic [31:0] pc,
                                   input logic flush, input logic free,
                                   input logic drv, input logic rdy, input logic [41:0] dat,
                                   input logic ovf, input logic perr, input logic tmo);
        vec_t v;
        v.rst = r; v.push = push; v.fo = fo; v.ep = ep; v.ct = ct; v.pc = pc;
        v.flush = flush; v.free = free;
        v.e_drive = drv; v.e_ready = rdy; v.e_data = dat;
        v.e_ovf = ovf; v.e_perr = perr; v.e_tmo = tmo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic model_edge(input bit r, input bit push, input logic [41:0] pkt,
                              input bit flush, input bit free);
        bit idle, has_head, room, free_ok, nxt_drive, nxt_wait;
        if (!r) begin
            m_q.delete();
            m_drive = 0; m_wait = 0; m_wd = 0;
            m_ovf = 0; m_perr = 0; m_tmo = 0;
            m_data = 42'd0; m_sent = 0; m_drop = 0;
            return;
        end
        idle      = !m_drive && !m_wait;
        has_head  = (m_q.size() > 0);
        room      = (m_q.size() < DEPTH);
        free_ok   = m_wait && free;
        nxt_drive = idle && has_head && !flush;
        nxt_wait  = m_drive || (m_wait && !free);
        if (free && !m_wait) m_perr = 1;
        if (nxt_drive) m_data = m_q[0];
        if (free_ok) begin
            void'(m_q.pop_front());
            m_sent++;
        end
        if (flush) begin
            if (idle || free_ok) m_q.delete();
            else while (m_q.size() > 1) void'(m_q.pop_back());
        end
        if (push) begin
            if (room) m_q.push_back(pkt);
            else begin
                m_ovf = 1;
                if (m_drop < 255) m_drop++;
            end
        end
        if (m_wait && !free) begin
            if (m_wd < TIMEOUT) m_wd++;
            if (m_wd == TIMEOUT) m_tmo = 1;
        end else begin
            m_wd = 0;
        end
        m_drive = nxt_drive;
        m_wait  = nxt_wait;
    endtask

    task automatic check_model();
        chk("drive", 64'(o_drive_to_back), 64'(m_drive));
        chk("ready", 64'(o_ready), 64'(m_q.size() < DEPTH));
        chk("data", 64'(o_data_42), 64'(m_data));
        chk("overflow", 64'(o_overflow), 64'(m_ovf));
        chk("protoErr", 64'(o_protoErr), 64'(m_perr));
        chk("timeout", 64'(o_timeout), 64'(m_tmo));
`ifdef BCORRECT_QUEUE_STATS_EN
        chk("sentCount", 64'(o_sentCount_16), 64'(m_sent[15:0]));
        chk("dropCount", 64'(o_dropCount_8), 64'(m_drop));
`endif
    endtask

    task automatic step(input logic r, input logic push, input logic fo, input logic [2:0] ep,
                        input logic [2:0] ct, input logic [31:0] pc, input logic flush,
                        input logic free, input bit use_model);
        rst = r; i_push = push; i_flushOnly = fo; i_errPos_3 = ep; i_counter_3 = ct;
        i_correctPc_32 = pc; i_flush = flush; i_free_from_back = free;
        @(posedge clk);
        model_edge(r, push, pack(fo, ep, ct, pc), flush, free);
        #1;
        if (use_model) check_model();
        if (o_drive_to_back === 1'b1) drives_seen++;
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic push1(input logic [2:0] ep, input logic [31:0] pc);
        step(1'b1, 1'b1, 1'b0, ep, 3'd1, pc, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic free1();
        step(1'b1, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    endtask

    initial begin
        logic [41:0] p1, pa;
        p1 = 42'h150_8000_1000;
        pa = pack(1'b1, 3'd7, 3'd7, 32'hFFFF_FFFF);

        // reset, single send/free, free in IDLE, fill to overflow, reset while full
        tbl.push_back(mkrow(0,0,0,3'd0,3'd0,32'h0,0,0,        0,1,42'd0,0,0,0));
        tbl.push_back(mkrow(1,1,0,3'd5,3'd2,32'h8000_1000,0,0, 0,1,42'd0,0,0,0));
        tbl.push_back(mkrow(1,0,0,3'd0,3'd0,32'h0,0,0,        1,1,p1,0,0,0));
        tbl.push_back(mkrow(1,0,0,3'd0,3'd0,32'h0,0,0,        0,1,p1,0,0,0));
        tbl.push_back(mkrow(1,0,0,3'd0,3'd0,32'h0,0,1,        0,1,p1,0,0,0));
        tbl.push_back(mkrow(1,0,0,3'd0,3'd0,32'h0,0,1,        0,1,p1,0,1,0));
        tbl.push_back(mkrow(1,0,0,3'd0,3'd0,32'h0,0,0,        0,1,p1,0,1,0));
        tbl.push_back(mkrow(1,1,1,3'd7,3'd7,32'hFFFF_FFFF,0,0, 0,1,p1,0,1,0));
        tbl.push_back(mkrow(1,1,0,3'd1,3'd4,32'h0000_0004,0,0, 1,1,pa,0,1,0));
        tbl.push_back(mkrow(1,1,0,3'd2,3'd3,32'h1234_5678,0,0, 0,1,pa,0,1,0));
        tbl.push_back(mkrow(1,1,1,3'd3,3'd2,32'hCAFE_0000,0,0, 0,0,pa,0,1,0));
        tbl.push_back(mkrow(1,1,0,3'd4,3'd1,32'hDEAD_BEEF,0,0, 0,0,pa,1,1,0));
        tbl.push_back(mkrow(1,0,0,3'd0,3'd0,32'h0,0,0,        0,0,pa,1,1,0));
        tbl.push_back(mkrow(0,1,1,3'd6,3'd6,32'h5555_5555,1,1, 0,1,42'd0,0,0,0));
        tbl.push_back(mkrow(1,0,0,3'd0,3'd0,32'h0,0,0,        0,1,42'd0,0,0,0));
        tbl.push_back(mkrow(1,0,0,3'd0,3'd0,32'h0,0,0,        0,1,42'd0,0,0,0));

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].push, tbl[i].fo, tbl[i].ep, tbl[i].ct, tbl[i].pc,
                 tbl[i].flush, tbl[i].free, 1'b0);
            chk($sformatf("tbl%0d_drive", i), 64'(o_drive_to_back), 64'(tbl[i].e_drive));
            chk($sformatf("tbl%0d_ready", i), 64'(o_ready), 64'(tbl[i].e_ready));
            chk($sformatf("tbl%0d_data", i), 64'(o_data_42), 64'(tbl[i].e_data));
            chk($sformatf("tbl%0d_ovf", i), 64'(o_overflow), 64'(tbl[i].e_ovf));
            chk($sformatf("tbl%0d_perr", i), 64'(o_protoErr), 64'(tbl[i].e_perr));
            chk($sformatf("tbl%0d_tmo", i), 64'(o_timeout), 64'(tbl[i].e_tmo));
        end

        // flush in WAIT with a simultaneous push keeps the head and the new entry
        drives_seen = 0;
        push1(3'd1, 32'h0000_1111);
        push1(3'd2, 32'h0000_2222);
        push1(3'd3, 32'h0000_3333);
        step(1'b1, 1'b1, 1'b0, 3'd4, 3'd1, 32'h0000_4444, 1'b1, 1'b0, 1'b1);
        free1();
        chk("gap_after_pop", 64'(o_drive_to_back), 64'd0);
        idle();
        chk("flush_second_data", 64'(o_data_42), 64'(pack(1'b0, 3'd4, 3'd1, 32'h0000_4444)));
        idle();
        free1();
        for (int k = 0; k < 4; k++) idle();
        chk("flush_drive_count", 64'(drives_seen), 64'd2);

        // watchdog fires after TIMEOUT cycles in WAIT and the handshake keeps waiting
        push1(3'd5, 32'h0000_5555);
        idle();
        idle();
        for (int k = 1; k <= TIMEOUT; k++) begin
            idle();
            if (k == TIMEOUT - 1) chk("timeout_early", 64'(o_timeout), 64'd0);
            if (k == TIMEOUT) chk("timeout_set", 64'(o_timeout), 64'd1);
        end
        free1();
        idle();

        // reset in WAIT with two entries abandons the handshake
        push1(3'd6, 32'h0000_6666);
        push1(3'd7, 32'h0000_7777);
        idle();
        step(1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        chk("rst_ready", 64'(o_ready), 64'd1);
        chk("rst_timeout", 64'(o_timeout), 64'd0);
        drives_seen = 0;
        for (int k = 0; k < 6; k++) idle();
        chk("rst_no_drive", 64'(drives_seen), 64'd0);

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic r, pu, fl, fr;
            r  = ($urandom_range(0, 199) != 0);
            pu = ($urandom_range(0, 1) == 1);
            fl = ($urandom_range(0, 15) == 0);
            fr = m_wait ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
            step(r, pu, 1'($urandom), 3'($urandom), 3'($urandom), $urandom, fl, fr, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
